// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: screen geometry defaults, scheduler states and column issue modes.
package raycast_pkg;

  localparam int unsigned SCREEN_WIDTH_DEFAULT  = 320;
  localparam int unsigned SCREEN_HEIGHT_DEFAULT = 240;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_DONE  = 2'd2
  } sched_state_t;

  typedef enum logic {
    MODE_FULL       = 1'b0,
    MODE_INTERLACED = 1'b1
  } mode_t;

endpackage

// File: rtl/ray_column_scheduler_rr_lane_pointer.sv
// Round-robin lane pointer: modulo-LANES counter with synchronous clear and advance.
module rr_lane_pointer #(
  parameter  int unsigned LANES = 2,
  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ptr_next_c
);

  // Clear wins over advance so a frame start always lands on lane 0.
  always_comb begin
    ptr_next_c = ptr;
    if (clear) begin
      ptr_next_c = '0;
    end else if (advance) begin
      ptr_next_c = (32'(ptr) == LANES - 1) ? '0 : ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next_c;
    end
  end

endmodule

// File: rtl/ray_column_scheduler.sv
// Issues screen column indices round-robin to downstream ray lanes, one frame per accepted
// frame_start_in, in full or interlaced (alternating even/odd) order.
module ray_column_scheduler
  import raycast_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = SCREEN_WIDTH_DEFAULT,
  parameter int unsigned LANES        = 2,
  parameter int unsigned HCOUNT_WIDTH = $clog2(SCREEN_WIDTH)
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic                    frame_start_in,
  input  logic                    mode_in,
  input  logic [LANES-1:0]        lane_tready_in,
  output logic [LANES-1:0]        lane_tvalid_out,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic                    tlast_out,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic                    overrun_out
);

  localparam int unsigned PTR_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LAST_FULL = SCREEN_WIDTH - 1;
  localparam int unsigned LAST_EVEN = ((SCREEN_WIDTH - 1) % 2 == 0) ? SCREEN_WIDTH - 1 : SCREEN_WIDTH - 2;
  localparam int unsigned LAST_ODD  = ((SCREEN_WIDTH - 1) % 2 == 1) ? SCREEN_WIDTH - 1 : SCREEN_WIDTH - 2;

  sched_state_t            state, state_nxt;
  mode_t                   mode_q, mode_nxt;
  logic                    parity_q, parity_nxt;
  logic [HCOUNT_WIDTH-1:0] last_col_q, last_col_nxt;
  logic [HCOUNT_WIDTH-1:0] hcount_nxt;
  logic [LANES-1:0]        tvalid_nxt;
  logic                    tlast_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;
  logic                    overrun_nxt;
  logic                    ptr_clear;
  logic                    ptr_advance;
  logic [PTR_W-1:0]        lane_ptr;
  logic [PTR_W-1:0]        lane_ptr_next;
  logic                    hs_c;
  logic [HCOUNT_WIDTH-1:0] start_col_c;
  logic [HCOUNT_WIDTH-1:0] step_c;

  rr_lane_pointer #(
    .LANES (LANES)
  ) u_lane_ptr (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .clear        (ptr_clear),
    .advance      (ptr_advance),
    .ptr          (lane_ptr),
    .ptr_next_c   (lane_ptr_next)
  );

  assign hs_c        = lane_tvalid_out[lane_ptr] && lane_tready_in[lane_ptr];
  assign start_col_c = mode_in ? HCOUNT_WIDTH'(parity_q) : '0;
  assign step_c      = (mode_q == MODE_INTERLACED) ? HCOUNT_WIDTH'(2) : HCOUNT_WIDTH'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode_q;
    parity_nxt   = parity_q;
    last_col_nxt = last_col_q;
    hcount_nxt   = hcount_out;
    tvalid_nxt   = lane_tvalid_out;
    tlast_nxt    = tlast_out;
    busy_nxt     = busy_out;
    done_nxt     = 1'b0;
    overrun_nxt  = 1'b0;
    ptr_clear    = 1'b0;
    ptr_advance  = 1'b0;

    unique case (state)
      SCHED_IDLE: begin
        if (frame_start_in) begin
          state_nxt  = SCHED_ISSUE;
          mode_nxt   = mode_t'(mode_in);
          ptr_clear  = 1'b1;
          hcount_nxt = start_col_c;
          if (!mode_in) begin
            last_col_nxt = HCOUNT_WIDTH'(LAST_FULL);
          end else if (parity_q) begin
            last_col_nxt = HCOUNT_WIDTH'(LAST_ODD);
          end else begin
            last_col_nxt = HCOUNT_WIDTH'(LAST_EVEN);
          end
          tlast_nxt  = (start_col_c == last_col_nxt);
          tvalid_nxt = LANES'(1);
          busy_nxt   = 1'b1;
        end
      end

      SCHED_ISSUE: begin
        overrun_nxt = frame_start_in;
        if (hs_c) begin
          if (tlast_out) begin
            state_nxt  = SCHED_DONE;
            tvalid_nxt = '0;
            tlast_nxt  = 1'b0;
            hcount_nxt = '0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
            if (mode_q == MODE_INTERLACED) begin
              parity_nxt = ~parity_q;
            end
          end else begin
            ptr_advance = 1'b1;
            hcount_nxt  = hcount_out + step_c;
            tlast_nxt   = (hcount_nxt == last_col_q);
            tvalid_nxt  = LANES'(1) << lane_ptr_next;
          end
        end
      end

      SCHED_DONE: begin
        // A start request landing on the return to idle is still an overrun.
        state_nxt   = SCHED_IDLE;
        overrun_nxt = frame_start_in;
      end

      default: begin
        state_nxt  = SCHED_IDLE;
        tvalid_nxt = '0;
        tlast_nxt  = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= SCHED_IDLE;
      mode_q          <= MODE_FULL;
      parity_q        <= 1'b0;
      last_col_q      <= '0;
      hcount_out      <= '0;
      lane_tvalid_out <= '0;
      tlast_out       <= 1'b0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      state           <= state_nxt;
      mode_q          <= mode_nxt;
      parity_q        <= parity_nxt;
      last_col_q      <= last_col_nxt;
      hcount_out      <= hcount_nxt;
      lane_tvalid_out <= tvalid_nxt;
      tlast_out       <= tlast_nxt;
      busy_out        <= busy_nxt;
      frame_done_out  <= done_nxt;
      overrun_out     <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Directed bench for ray_column_scheduler across three geometries (8x2 full, 7x3 interlaced, 2x1).
module tb_ray_column_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: SCREEN_WIDTH=8, LANES=2
  logic       fs_a = 1'b0, mode_a = 1'b0;
  logic [1:0] rdy_a = 2'b00, va;
  logic [2:0] ha;
  logic       la, ba, da, oa;

  // Instance B: SCREEN_WIDTH=7, LANES=3
  logic       fs_b = 1'b0, mode_b = 1'b0;
  logic [2:0] rdy_b = 3'b000, vb;
  logic [2:0] hb;
  logic       lb, bb, db, ob;

  // Instance C: SCREEN_WIDTH=2, LANES=1
  logic       fs_c = 1'b0, mode_c = 1'b0;
  logic [0:0] rdy_c = 1'b0, vc;
  logic [0:0] hc;
  logic       lc, bc, dc, oc;

  ray_column_scheduler #(.SCREEN_WIDTH(8), .LANES(2)) dut_a (
    .pixel_clk_in(clk), .rst_in(rst), .frame_start_in(fs_a), .mode_in(mode_a),
    .lane_tready_in(rdy_a), .lane_tvalid_out(va), .hcount_out(ha), .tlast_out(la),
    .busy_out(ba), .frame_done_out(da), .overrun_out(oa));

  ray_column_scheduler #(.SCREEN_WIDTH(7), .LANES(3)) dut_b (
    .pixel_clk_in(clk), .rst_in(rst), .frame_start_in(fs_b), .mode_in(mode_b),
    .lane_tready_in(rdy_b), .lane_tvalid_out(vb), .hcount_out(hb), .tlast_out(lb),
    .busy_out(bb), .frame_done_out(db), .overrun_out(ob));

  ray_column_scheduler #(.SCREEN_WIDTH(2), .LANES(1)) dut_c (
    .pixel_clk_in(clk), .rst_in(rst), .frame_start_in(fs_c), .mode_in(mode_c),
    .lane_tready_in(rdy_c), .lane_tvalid_out(vc), .hcount_out(hc), .tlast_out(lc),
    .busy_out(bc), .frame_done_out(dc), .overrun_out(oc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_a_valid", 32'(va), 0);
    chk("rst_a_hcount", 32'(ha), 0);
    chk("rst_a_flags", {28'd0, la, ba, da, oa}, 0);
    chk("rst_b_valid", 32'(vb), 0);
    chk("rst_c_valid", 32'(vc), 0);
    rst = 1'b0;
    tick();

    // A: full frame, all ready
    fs_a = 1'b1; mode_a = 1'b0; rdy_a = 2'b11;
    tick(); fs_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("a_full_hcount", 32'(ha), i);
      chk("a_full_lane", 32'(va), (i % 2 == 0) ? 1 : 2);
      chk("a_full_tlast", 32'(la), (i == 7) ? 1 : 0);
      chk("a_full_busy", 32'(ba), 1);
      tick();
    end
    chk("a_full_done", 32'(da), 1);
    chk("a_full_valid_off", 32'(va), 0);
    chk("a_full_busy_off", 32'(ba), 0);
    tick();
    chk("a_full_done_pulse", 32'(da), 0);

    // A: backpressure on lane 1, then overrun mid-frame with mode change
    fs_a = 1'b1;
    tick(); fs_a = 1'b0;
    chk("a_bp_h0", 32'(ha), 0);
    tick();
    chk("a_bp_h1", 32'(ha), 1);
    rdy_a = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("a_bp_hold_hcount", 32'(ha), 1);
      chk("a_bp_hold_valid", 32'(va), 2);
      chk("a_bp_hold_tlast", 32'(la), 0);
    end
    rdy_a = 2'b11;
    tick();
    chk("a_bp_h2", 32'(ha), 2);
    chk("a_bp_h2_lane", 32'(va), 1);
    tick();
    chk("a_ov_h3", 32'(ha), 3);
    fs_a = 1'b1; mode_a = 1'b1;
    tick(); fs_a = 1'b0; mode_a = 1'b0;
    chk("a_ov_pulse", 32'(oa), 1);
    chk("a_ov_h4", 32'(ha), 4);
    chk("a_ov_busy", 32'(ba), 1);
    tick();
    chk("a_ov_pulse_end", 32'(oa), 0);
    chk("a_ov_h5", 32'(ha), 5);
    tick();
    chk("a_ov_h6", 32'(ha), 6);
    tick();
    chk("a_ov_h7", 32'(ha), 7);
    chk("a_ov_tlast", 32'(la), 1);
    tick();
    chk("a_ov_done", 32'(da), 1);
    chk("a_ov_no_overrun", 32'(oa), 0);
    fs_a = 1'b1;
    tick(); fs_a = 1'b0;
    chk("a_done_start_overrun", 32'(oa), 1);
    chk("a_done_single", 32'(da), 0);
    chk("a_done_start_valid", 32'(va), 0);
    tick();
    chk("a_done_start_ignored", {30'd0, va}, 0);
    chk("a_done_start_busy", 32'(ba), 0);

    // A: interlaced frame (parity 0) sets parity to 1
    fs_a = 1'b1; mode_a = 1'b1;
    tick(); fs_a = 1'b0; mode_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("a_il_hcount", 32'(ha), 2 * i);
      chk("a_il_lane", 32'(va), (i % 2 == 0) ? 1 : 2);
      chk("a_il_tlast", 32'(la), (i == 3) ? 1 : 0);
      tick();
    end
    chk("a_il_done", 32'(da), 1);
    tick();

    // A: full frame aborted by reset at hcount 4
    fs_a = 1'b1;
    tick(); fs_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("a_abort_hcount", 32'(ha), i);
      if (i < 4) tick();
    end
    #1 rst = 1'b1;
    #1;
    chk("a_abort_valid", 32'(va), 0);
    chk("a_abort_hcount0", 32'(ha), 0);
    chk("a_abort_flags", {28'd0, la, ba, da, oa}, 0);
    tick(); rst = 1'b0;
    tick();
    chk("a_abort_no_done", 32'(da), 0);
    fs_a = 1'b1; mode_a = 1'b1;
    tick(); fs_a = 1'b0; mode_a = 1'b0;
    chk("a_post_rst_h0", 32'(ha), 0);
    chk("a_post_rst_lane0", 32'(va), 1);
    tick();
    chk("a_post_rst_h2", 32'(ha), 2);
    chk("a_post_rst_lane1", 32'(va), 2);

    // B: two interlaced frames, SCREEN_WIDTH=7, LANES=3
    fs_b = 1'b1; mode_b = 1'b1; rdy_b = 3'b111;
    tick(); fs_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_even_hcount", 32'(hb), 2 * i);
      chk("b_even_lane", 32'(vb), 1 << (i % 3));
      chk("b_even_tlast", 32'(lb), (i == 3) ? 1 : 0);
      tick();
    end
    chk("b_even_done", 32'(db), 1);
    tick();
    fs_b = 1'b1;
    tick(); fs_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_odd_hcount", 32'(hb), 2 * i + 1);
      chk("b_odd_lane", 32'(vb), 1 << i);
      chk("b_odd_tlast", 32'(lb), (i == 2) ? 1 : 0);
      tick();
    end
    chk("b_odd_done", 32'(db), 1);
    chk("b_odd_valid_off", 32'(vb), 0);

    // C: SCREEN_WIDTH=2, LANES=1
    fs_c = 1'b1; mode_c = 1'b0; rdy_c = 1'b1;
    tick(); fs_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("c_hcount", 32'(hc), i);
      chk("c_lane", 32'(vc), 1);
      chk("c_tlast", 32'(lc), (i == 1) ? 1 : 0);
      tick();
    end
    chk("c_done", 32'(dc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ray_column_scheduler.md
RAY_COLUMN_SCHEDULER -- requirements
Module: ray_column_scheduler

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320: columns per full frame, range 2..2048.
REQ-002 Parameter LANES, default 2: number of downstream ray-calculation lanes, range 1..8.
REQ-003 Parameter HCOUNT_WIDTH, default $clog2(SCREEN_WIDTH): column index width.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 pixel_clk_in  in  1  sole clock, all state changes on its rising edge.
REQ-006 rst_in  in  1  asynchronous, active-high reset.
REQ-007 frame_start_in  in  1  one-cycle pulse that requests one frame of column issue.
REQ-008 mode_in  in  1  0 = full (every column); 1 = interlaced (half the columns per frame); sampled on accepted frame_start_in.
REQ-009 lane_tready_in  in  LANES  per-lane ready from the downstream lane FIFO.
REQ-010 lane_tvalid_out  out  LANES  per-lane valid, at most one bit high.
REQ-011 hcount_out  out  HCOUNT_WIDTH  column index of the current beat, shared by all lanes.
REQ-012 tlast_out  out  1  high on the final beat of the frame.
REQ-013 busy_out  out  1  high from frame acceptance until the last beat handshakes.
REQ-014 frame_done_out  out  1  one-cycle pulse on the cycle after the last handshake.
REQ-015 overrun_out  out  1  one-cycle pulse when frame_start_in arrives while busy.

Function
REQ-016 States: IDLE, ISSUE, DONE. IDLE->ISSUE on frame_start_in; ISSUE->DONE on the handshake of the tlast beat; DONE->IDLE unconditionally after 1 cycle (frame_done_out high in DONE).
REQ-017 A handshake is lane_tvalid_out[k] && lane_tready_in[k] on the selected lane k.
REQ-018 First beat is valid on the cycle after frame_start_in is accepted (latency 1).
REQ-019 Full mode issues columns 0,1,...,SCREEN_WIDTH-1 in order.
REQ-020 Interlaced mode issues even columns (0,2,...) when frame parity is 0 and odd columns (1,3,...) when it is 1; parity toggles on each completed interlaced frame and is not changed by full-mode frames.
REQ-021 In interlaced mode, the last beat is the largest column below SCREEN_WIDTH with the current parity, including odd SCREEN_WIDTH.
REQ-022 Beats go round-robin to lanes: the n-th beat of a frame (n from 0) goes to lane n mod LANES; the lane pointer resets to 0 at every frame start.
REQ-023 While valid and not ready, hcount_out, tlast_out and lane_tvalid_out hold stable (AXI-stream rule); the scheduler never withdraws valid.
REQ-024 Throughput is 1 beat per cycle when the selected lane's ready is held high.
REQ-025 The column counter and the lane pointer advance only on a handshake; the column counter never wraps within a frame.
REQ-026 frame_start_in in ISSUE or DONE is ignored for issue purposes and pulses overrun_out for 1 cycle; the running frame continues unchanged.
REQ-027 A frame_start_in in the same cycle as the DONE->IDLE transition counts as overrun, not as a new frame.
REQ-028 lane_tready_in bits of non-selected lanes have no effect.
REQ-029 mode_in changes in mid-frame have no effect until the next accepted frame.

Reset
REQ-030 On rst_in assertion, at any time including mid-frame: state = IDLE; lane_tvalid_out = 0; hcount_out = 0; tlast_out = 0; busy_out = 0; frame_done_out = 0; overrun_out = 0; lane pointer = 0; parity = 0.
REQ-031 An aborted frame is not resumed after reset and produces no frame_done_out.
REQ-032 The first frame_start_in after reset release is accepted normally.

Structure
REQ-033 The following belong in shared package raycast_pkg:
- SCREEN_WIDTH and SCREEN_HEIGHT defaults;
- the scheduler state enum;
- the mode enum (MODE_FULL, MODE_INTERLACED).
REQ-034 One sub-module, rr_lane_pointer (modulo-LANES counter with advance and clear inputs); all other logic is inline.

Verification
REQ-035 Full mode, SCREEN_WIDTH=8, LANES=2, all ready = 1:
- frame_start at cycle t -> hcount 0..7 on cycles t+1..t+8;
- lanes alternate 0,1,...;
- tlast at hcount=7;
- frame_done at t+9.
REQ-036 Interlaced mode, SCREEN_WIDTH=7, LANES=3:
- frame 1 -> hcount 0,2,4,6 on lanes 0,1,2,0, tlast on 6;
- frame 2 -> hcount 1,3,5, tlast on 5.
REQ-037 Backpressure: lane 1 ready = 0 for 5 cycles while hcount=1 is pending -> hcount, tlast and valid stay stable; hcount 2 follows 1 cycle after ready rises.
REQ-038 frame_start pulse during ISSUE (hcount=3) -> overrun pulse of 1 cycle; the sequence continues to 7; exactly one frame_done.
REQ-039 rst_in asserted while hcount=4 -> all outputs 0 immediately; the next frame_start restarts at hcount 0 on lane 0 with parity 0.
REQ-040 LANES=1, SCREEN_WIDTH=2 -> beats 0,1 both on lane 0, tlast on 1.
